// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchronizer, debounce, press/release/long
// events, sticky pending flags and a registered interrupt.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter bit PRESSED_LEVEL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] evt_pending,
  input  logic [N_BTN-1:0] evt_clr,
  output logic             irq
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic [N_BTN-1:0] raw_norm;
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] diff;
  logic [N_BTN-1:0] db_done;
  logic [N_BTN-1:0] hold_done;
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] hold_hit;

  logic [DW-1:0] db_cnt   [N_BTN];
  logic [HW-1:0] hold_cnt [N_BTN];

  assign raw_norm = PRESSED_LEVEL ? btn_raw : ~btn_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_norm;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    db_done   = '0;
    hold_done = '0;
    for (int i = 0; i < N_BTN; i++) begin
      db_done[i]   = (db_cnt[i] == DB_LAST);
      hold_done[i] = (hold_cnt[i] == HOLD_LAST);
    end
  end

  // flip: this edge completes a full stable mismatch run
  assign diff     = sync_q2 ^ btn_level;
  assign flip     = diff & db_done;
  assign hold_hit = btn_level & ~flip & hold_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      btn_level   <= btn_level ^ flip;
      btn_press   <= flip & ~btn_level;
      btn_release <= flip & btn_level;
      btn_long    <= hold_hit;
      for (int i = 0; i < N_BTN; i++) begin
        if (!diff[i] || flip[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
        // saturating hold keeps btn_long from repeating
        if (!btn_level[i] || flip[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_pending <= '0;
      irq         <= 1'b0;
    end else begin
      evt_pending <= (evt_pending & ~evt_clr) | btn_press;
      irq         <= |evt_pending;
    end
  end

endmodule
